// File: rtl/mon_capture.sv
// Triggered waveform capture: reduces 2^navr-sample windows of NCHAN monitor
// streams to one point each (average or sub-sample) and writes them to the dpram.
//
//   state    | meaning
//   ARMED    | idle, waiting for trig; capture settings latched on trig
//   HOLD     | holdoff down-counter running (dt cycles)
//   CAPT     | windows being accumulated, one point per window
//   DONE     | 2^MEMAW points written, stopped=1 until reset
module mon_capture #(
  parameter int DW      = 16,
  parameter int NCHAN   = 2,
  parameter int MEMAW   = 10,
  parameter int MAXDAVR = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig,
  input  logic [DW*NCHAN-1:0]   din,
  input  logic [1:0]            opsel,
  input  logic [4:0]            navr,
  input  logic [15:0]           dt,
  output logic [DW*NCHAN-1:0]   dout,
  output logic                  gout,
  output logic [MEMAW-1:0]      addrcnt,
  output logic                  stopped
);

  localparam int AW = DW + MAXDAVR;

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0]         NAVR_MAX = 5'(MAXDAVR);
  localparam logic [MAXDAVR-1:0] ONES     = '1;

  logic [1:0]                  state_q, state_d;
  logic                        sub_mode_q, sub_mode_d;
  logic [4:0]                  navr_q, navr_d;
  logic [15:0]                 hold_q, hold_d;
  logic [MAXDAVR-1:0]          win_q, win_d;
  logic                        first_q, first_d;
  logic [NCHAN-1:0][AW-1:0]    acc_q, acc_d;
  logic [NCHAN-1:0][DW-1:0]    sub_q, sub_d;
  logic [DW*NCHAN-1:0]         dout_q, dout_d;
  logic                        gout_q, gout_d;
  logic [MEMAW-1:0]            addr_q, addr_d;

  logic [4:0]                  navr_clamp;
  logic                        last_pt;
  logic [AW-1:0]               ext_w [NCHAN];
  logic signed [AW-1:0]        sum_w [NCHAN];
  logic [DW-1:0]               avg_w [NCHAN];
  logic [DW-1:0]               smp_w [NCHAN];

  assign navr_clamp = (navr > NAVR_MAX) ? NAVR_MAX : navr;
  assign last_pt    = gout_q && (addr_q == '1);

  // Running sum includes the current sample so the window-end point needs no extra cycle.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      ext_w[c] = {{MAXDAVR{din[c*DW+DW-1]}}, din[c*DW +: DW]};
      sum_w[c] = (first_q ? '0 : acc_q[c]) + ext_w[c];
      avg_w[c] = DW'(sum_w[c] >>> navr_q);
      smp_w[c] = first_q ? din[c*DW +: DW] : sub_q[c];
    end
  end

  always_comb begin
    state_d    = state_q;
    sub_mode_d = sub_mode_q;
    navr_d     = navr_q;
    hold_d     = hold_q;
    win_d      = win_q;
    first_d    = first_q;
    acc_d      = acc_q;
    sub_d      = sub_q;
    dout_d     = dout_q;
    gout_d     = 1'b0;
    addr_d     = gout_q ? addr_q + 1'b1 : addr_q;

    case (state_q)
      ST_ARMED: begin
        if (trig) begin
          sub_mode_d = (opsel == 2'd1);
          navr_d     = navr_clamp;
          hold_d     = dt;
          win_d      = ~(ONES << navr_clamp);
          first_d    = 1'b1;
          state_d    = (dt != 16'd0) ? ST_HOLD : ST_CAPT;
        end
      end
      ST_HOLD: begin
        if (hold_q == 16'd1) begin
          hold_d  = 16'd0;
          state_d = ST_CAPT;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      ST_CAPT: begin
        if (last_pt) begin
          state_d = ST_DONE;
        end else begin
          for (int c = 0; c < NCHAN; c++) begin
            acc_d[c] = sum_w[c];
            if (first_q) sub_d[c] = din[c*DW +: DW];
          end
          if (win_q == '0) begin
            gout_d  = 1'b1;
            for (int c = 0; c < NCHAN; c++)
              dout_d[c*DW +: DW] = sub_mode_q ? smp_w[c] : avg_w[c];
            win_d   = ~(ONES << navr_q);
            first_d = 1'b1;
          end else begin
            win_d   = win_q - 1'b1;
            first_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      sub_mode_q <= 1'b0;
      navr_q     <= 5'd0;
      hold_q     <= 16'd0;
      win_q      <= '0;
      first_q    <= 1'b0;
      acc_q      <= '0;
      sub_q      <= '0;
      dout_q     <= '0;
      gout_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      sub_mode_q <= sub_mode_d;
      navr_q     <= navr_d;
      hold_q     <= hold_d;
      win_q      <= win_d;
      first_q    <= first_d;
      acc_q      <= acc_d;
      sub_q      <= sub_d;
      dout_q     <= dout_d;
      gout_q     <= gout_d;
      addr_q     <= addr_d;
    end
  end

  // Strobe is masked while reset is held so an aborted capture writes nothing.
  assign gout    = gout_q & ~reset;
  assign dout    = dout_q;
  assign addrcnt = addr_q;
  assign stopped = (state_q == ST_DONE);

endmodule

// File: tb/tb_mon_capture.sv
// Scoreboard bench for mon_capture: default-size instance A plus a small
// instance B (MEMAW=2, MAXDAVR=6) for clamp/overflow behaviour.
module tb_mon_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_a, trig_a;
  logic [31:0] din_a, dout_a;
  logic [1:0]  opsel_a;
  logic [4:0]  navr_a;
  logic [15:0] dt_a;
  logic        gout_a, stopped_a;
  logic [9:0]  addr_a;

  logic        reset_b, trig_b;
  logic [31:0] din_b, dout_b;
  logic [1:0]  opsel_b;
  logic [4:0]  navr_b;
  logic [15:0] dt_b;
  logic        gout_b, stopped_b;
  logic [1:0]  addr_b;

  mon_capture u_a (
    .clk(clk), .reset(reset_a), .trig(trig_a), .din(din_a), .opsel(opsel_a),
    .navr(navr_a), .dt(dt_a), .dout(dout_a), .gout(gout_a), .addrcnt(addr_a),
    .stopped(stopped_a));

  mon_capture #(.DW(16), .NCHAN(2), .MEMAW(2), .MAXDAVR(6)) u_b (
    .clk(clk), .reset(reset_b), .trig(trig_b), .din(din_b), .opsel(opsel_b),
    .navr(navr_b), .dt(dt_b), .dout(dout_b), .gout(gout_b), .addrcnt(addr_b),
    .stopped(stopped_b));

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          cyc;
    int          addr;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (gout_a) begin
      total++;
      if (qa.size() == 0) begin
        $display("FAIL point_a: unexpected gout at cycle %0d addr %0d, required no strobe", cyc, addr_a);
      end else begin
        ea = qa.pop_front();
        if (ea.cyc == cyc && ea.addr == int'(addr_a) && ea.d0 == dout_a[15:0] && ea.d1 == dout_a[31:16])
          passed++;
        else
          $display("FAIL point_a: got cyc %0d addr %0d d0 %h d1 %h, required cyc %0d addr %0d d0 %h d1 %h",
                   cyc, addr_a, dout_a[15:0], dout_a[31:16], ea.cyc, ea.addr, ea.d0, ea.d1);
      end
    end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      total++;
      ea = qa.pop_front();
      $display("FAIL point_a: no gout at cycle %0d, required point addr %0d at cycle %0d", cyc, ea.addr, ea.cyc);
    end
  end

  always @(negedge clk) begin
    if (gout_b) begin
      total++;
      if (qb.size() == 0) begin
        $display("FAIL point_b: unexpected gout at cycle %0d addr %0d, required no strobe", cyc, addr_b);
      end else begin
        eb = qb.pop_front();
        if (eb.cyc == cyc && eb.addr == int'(addr_b) && eb.d0 == dout_b[15:0] && eb.d1 == dout_b[31:16])
          passed++;
        else
          $display("FAIL point_b: got cyc %0d addr %0d d0 %h d1 %h, required cyc %0d addr %0d d0 %h d1 %h",
                   cyc, addr_b, dout_b[15:0], dout_b[31:16], eb.cyc, eb.addr, eb.d0, eb.d1);
      end
    end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      total++;
      eb = qb.pop_front();
      $display("FAIL point_b: no gout at cycle %0d, required point addr %0d at cycle %0d", cyc, eb.addr, eb.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int c, input int a, input logic [15:0] d0, input logic [15:0] d1);
    exp_t e;
    e.cyc = c; e.addr = a; e.d0 = d0; e.d1 = d1;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input int a, input logic [15:0] d0, input logic [15:0] d1);
    exp_t e;
    e.cyc = c; e.addr = a; e.d0 = d0; e.d1 = d1;
    qb.push_back(e);
  endtask

  // Average-test windows: even windows -> ch0 -2, ch1 5; odd windows -> ch0 7, ch1 -8
  logic [15:0] pe0 [4] = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF};
  logic [15:0] pe1 [4] = '{16'd4, 16'd5, 16'd6, 16'd8};
  logic [15:0] po0 [4] = '{16'd7, 16'd7, 16'd7, 16'd8};
  logic [15:0] po1 [4] = '{16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF9};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    reset_a = 1'b1; trig_a = 1'b0; din_a = '0; opsel_a = 2'd0; navr_a = 5'd0; dt_a = 16'd0;
    reset_b = 1'b1; trig_b = 1'b0; din_b = '0; opsel_b = 2'd0; navr_b = 5'd0; dt_b = 16'd0;
    repeat (3) step();
    reset_a = 1'b0; reset_b = 1'b0;
    step();
    chk("rst_dout_a", dout_a, 0);
    chk("rst_gout_a", gout_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_stopped_a", stopped_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_stopped_b", stopped_b, 0);
    while (cyc < 100) step();

    // Sub-sample ramp, no holdoff: trig at cycle 100
    t = cyc;
    opsel_a = 2'd1; navr_a = 5'd0; dt_a = 16'd0; trig_a = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      step();
      trig_a = 1'b0;
      din_a = {16'(16'hFFFF - k), 16'(k)};
      push_a(cyc + 1, k, 16'(k), 16'(16'hFFFF - k));
    end
    step();
    chk("ramp_final_addr", addr_a, 1023);
    chk("ramp_stopped_before", stopped_a, 0);
    trig_a = 1'b1;
    step();
    trig_a = 1'b0;
    chk("ramp_stopped_cycle", cyc - t, 1026);
    chk("ramp_stopped", stopped_a, 1);
    chk("ramp_addr_wrap", addr_a, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      trig_a = (i % 3 == 0);
    end
    trig_a = 1'b0;
    step();
    chk("done_hold_stopped", stopped_a, 1);

    // reset and trig in the same cycle: reset wins, nothing starts
    reset_a = 1'b1; trig_a = 1'b1;
    step();
    reset_a = 1'b0; trig_a = 1'b0;
    chk("coll_gout", gout_a, 0);
    chk("coll_addr", addr_a, 0);
    chk("coll_stopped", stopped_a, 0);
    repeat (10) step();
    chk("coll_idle_addr", addr_a, 0);

    // Average, navr=2, with control changes and trig pulses mid-capture
    opsel_a = 2'd0; navr_a = 5'd2; dt_a = 16'd0; trig_a = 1'b1;
    for (int j = 0; j < 1024; j++) begin
      for (int s = 0; s < 4; s++) begin
        step();
        trig_a = (j == 200 && s == 1);
        if (j == 100) begin opsel_a = 2'd1; navr_a = 5'd0; dt_a = 16'd9; end
        din_a = (j % 2 == 0) ? {pe1[s], pe0[s]} : {po1[s], po0[s]};
        if (s == 3) begin
          if (j % 2 == 0) push_a(cyc + 1, j, 16'hFFFE, 16'h0005);
          else            push_a(cyc + 1, j, 16'h0007, 16'hFFF8);
        end
      end
    end
    step();
    step();
    chk("avg_stopped", stopped_a, 1);

    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    step();
    chk("rearm_stopped", stopped_a, 0);

    // Holdoff dt=5, then reset when addrcnt reaches 300
    t = cyc;
    opsel_a = 2'd1; navr_a = 5'd0; dt_a = 16'd5; trig_a = 1'b1;
    for (int h = 0; h < 5; h++) begin
      step();
      trig_a = 1'b0;
      din_a = 32'hDEADDEAD;
    end
    for (int k = 0; k <= 300; k++) begin
      step();
      trig_a = (k == 50 || k == 51);
      din_a = {16'(k + 2000), 16'(k + 1000)};
      if (k == 0) chk("hold_first_sample_cycle", cyc - t, 6);
      if (k < 300) push_a(cyc + 1, k, 16'(k + 1000), 16'(k + 2000));
    end
    trig_a = 1'b0;
    step();
    chk("mid_reset_addr_before", addr_a, 300);
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    chk("mid_reset_gout", gout_a, 0);
    chk("mid_reset_addr", addr_a, 0);
    chk("mid_reset_stopped", stopped_a, 0);
    step();
    chk("mid_reset_gout_next", gout_a, 0);

    // Fresh capture after reset: navr=0 average equals the sample
    opsel_a = 2'd0; navr_a = 5'd0; dt_a = 16'd0; trig_a = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      step();
      trig_a = 1'b0;
      din_a = {16'(16'h8000 + k), 16'(-k)};
      push_a(cyc + 1, k, 16'(-k), 16'(16'h8000 + k));
    end
    step();
    step();
    chk("full2_stopped", stopped_a, 1);
    chk("full2_addr", addr_a, 0);

    // Instance B: navr=31 clamps to 6, full-scale constants, navr change ignored
    t = cyc;
    opsel_b = 2'd0; navr_b = 5'd31; dt_b = 16'd1; trig_b = 1'b1;
    din_b = {16'h8000, 16'h7FFF};
    step();
    trig_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 10) navr_b = 5'd0;
      if (i % 64 == 63) push_b(cyc + 1, i / 64, 16'h7FFF, 16'h8000);
    end
    step();
    chk("b_stopped_before", stopped_b, 0);
    step();
    chk("b_stopped", stopped_b, 1);
    chk("b_stopped_cycle", cyc - t, 259);

    repeat (5) step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
